fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 5'b00000, value of instruc[15:11] that marks HALT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  decode not ready; held instruction SHALL be kept.
REQ-006 redirect  input  1  branch/jump taken; load redirect_PC.
REQ-007 redirect_PC  input  16  new PC target.
REQ-008 mem_data  input  16  instruction word from instruction memory.
REQ-009 mem_rdy  input  1  mem_data valid this cycle for the current request.
REQ-010 mem_addr  output  16  instruction memory address.
REQ-011 mem_rd  output  1  instruction memory read request.
REQ-012 instruc  output  16  fetched instruction to decode.
REQ-013 seq_PC  output  16  address of instruc plus 2, to decode.
REQ-014 instr_valid  output  1  instruc/seq_PC valid for decode.
REQ-015 halted  output  1  HALT fetched; fetch stopped.

Function
REQ-016 Internal registers SHALL be PC[15:0] and a 3-state FSM: FETCH, HOLD, HALTED.
REQ-017 mem_addr SHALL equal PC combinationally in all states.
REQ-018 mem_rd SHALL be 1 in FETCH and 0 in HOLD and HALTED.
REQ-019 mem_rd SHALL be 0 in any cycle where redirect=1.
REQ-020 FETCH with mem_rdy=1 and redirect=0: instruc<=mem_data, seq_PC<=PC+2, PC<=PC+2, instr_valid<=1, next state HOLD.
REQ-021 FETCH with mem_rdy=0: stay in FETCH; hold PC; mem_rd stays 1 with mem_addr stable.
REQ-022 HOLD: instr_valid=1; instruc and seq_PC SHALL not change.
REQ-023 HOLD with stall=1: remain in HOLD.
REQ-024 HOLD with stall=0: the instruction is consumed that cycle.
REQ-025 HOLD with stall=0 and instruc[15:11]!=HALT_OPCODE: instr_valid<=0, next state FETCH.
REQ-026 HOLD with stall=0 and instruc[15:11]==HALT_OPCODE: instr_valid<=0, halted<=1, next state HALTED.
REQ-027 Minimum throughput is one instruction per 2 cycles (FETCH, HOLD); each extra mem_rdy=0 cycle adds one cycle.
REQ-028 redirect=1 in FETCH or HOLD: PC<={redirect_PC[15:1],1'b0}, instr_valid<=0, next state FETCH.
REQ-029 Redirect SHALL take priority over mem_rdy and stall; mem_data arriving in the same cycle SHALL be discarded.
REQ-030 HALTED: PC frozen, mem_rd=0, instr_valid=0, halted=1; redirect, stall and mem_rdy SHALL be ignored.
REQ-031 PC+2 SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000) with no flag.
REQ-032 seq_PC arithmetic SHALL be 16-bit unsigned; any carry-out is dropped.

Reset
REQ-033 rst=0 SHALL immediately, regardless of clk, force PC=RESET_PC, FSM=FETCH, instruc=16'h0000, seq_PC=16'h0000, instr_valid=0, halted=0.
REQ-034 During reset mem_rd SHALL be 0.
REQ-035 A request in flight at reset assertion SHALL be abandoned; a mem_rdy seen during reset SHALL be ignored.
REQ-036 First rising clk edge after rst returns to 1 SHALL be in FETCH with mem_addr=RESET_PC and mem_rd=1.

Verification
REQ-037 Reset release, mem_rdy=1 every cycle, mem_data=16'h4000 -> mem_addr 0000,0002,0004 on alternate cycles; seq_PC 0002,0004,0006 with instr_valid=1 in HOLD cycles.
REQ-038 mem_rdy low 3 cycles at PC=16'h0002 -> mem_rd=1 and mem_addr=16'h0002 stable for 4 cycles; instruc updates only in the mem_rdy=1 cycle.
REQ-039 stall=1 for 5 cycles while holding instruc=16'hC123 -> instruc=16'hC123, seq_PC unchanged and instr_valid=1 for all 5 cycles; FETCH resumes the cycle after stall=0.
REQ-040 redirect=1 with redirect_PC=16'h0101 in the same cycle as mem_rdy=1 -> data discarded; instr_valid=0; next mem_addr=16'h0100.
REQ-041 mem_data=16'h0000 (HALT) fetched, stall=0 -> one HOLD cycle with instr_valid=1, then halted=1 and mem_rd=0 held; later redirect and mem_rdy have no effect until rst=0.
REQ-042 PC=16'hFFFE fetched -> seq_PC=16'h0000; next mem_addr=16'h0000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the decode-facing outputs.
// master = the fetch stage itself, slave = the memory/decode environment driving it.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_PC;
  logic [15:0] mem_data;
  logic        mem_rdy;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] instruc;
  logic [15:0] seq_PC;
  logic        instr_valid;
  logic        halted;

  modport master (
    input  stall, redirect, redirect_PC, mem_data, mem_rdy,
    output mem_addr, mem_rd, instruc, seq_PC, instr_valid, halted
  );

  modport slave (
    output stall, redirect, redirect_PC, mem_data, mem_rdy,
    input  mem_addr, mem_rd, instruc, seq_PC, instr_valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: FETCH/HOLD/HALTED machine issuing one request per instruction
// and holding each fetched word for decode until it is consumed or a redirect flushes it.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fe_io
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instruc_q, instruc_d;
  logic [15:0] seq_pc_q, seq_pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] pc_plus2;
  logic [15:0] redirect_target;

  // 16-bit sum: the carry out of 16'hFFFE + 2 is intentionally dropped.
  assign pc_plus2        = pc_q + 16'd2;
  assign redirect_target = {fe_io.redirect_PC[15:1], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instruc_q <= 16'h0000;
      seq_pc_q  <= 16'h0000;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instruc_q <= instruc_d;
      seq_pc_q  <= seq_pc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instruc_d = instruc_q;
    seq_pc_d  = seq_pc_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    case (state_q)
      FETCH: begin
        if (fe_io.redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
        end else if (fe_io.mem_rdy) begin
          instruc_d = fe_io.mem_data;
          seq_pc_d  = pc_plus2;
          pc_d      = pc_plus2;
          valid_d   = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        // A redirect flushes the held word even if decode is stalled.
        if (fe_io.redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!fe_io.stall) begin
          valid_d = 1'b0;
          if (instruc_q[15:11] == HALT_OPCODE) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Reset gates the request so nothing is issued while rst is low.
  assign fe_io.mem_addr    = pc_q;
  assign fe_io.mem_rd      = rst && (state_q == FETCH) && !fe_io.redirect;
  assign fe_io.instruc     = instruc_q;
  assign fe_io.seq_PC      = seq_pc_q;
  assign fe_io.instr_valid = valid_q;
  assign fe_io.halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model predicts fetched words into a
// scoreboard queue; a separate monitor checks bus outputs and pops words as decode consumes them.
module tb_fetch_stage;
  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] spc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .HALT_OPCODE(HALT_OPCODE)) dut (
    .clk   (clk),
    .rst   (rst),
    .fe_io (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en   = 1'b0;
  exp_t        exp_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_last;
  bit          m_pending;
  bit          m_halted;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: only the stream of addresses and words matters, not the state encoding.
  task automatic model_step();
    if (m_halted) return;
    if (bus.redirect) begin
      m_pc      = {bus.redirect_PC[15:1], 1'b0};
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (!bus.stall) begin
        m_pending = 1'b0;
        if (m_last[15:11] == HALT_OPCODE) m_halted = 1'b1;
      end
    end else if (bus.mem_rdy) begin
      exp_q.push_back('{ins: bus.mem_data, spc: 16'(m_pc + 16'd2)});
      m_last    = bus.mem_data;
      m_pc      = 16'(m_pc + 16'd2);
      m_pending = 1'b1;
    end
  endtask

  task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc,
                       input logic rdy, input logic [15:0] d);
    @(negedge clk);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_PC = rpc;
    bus.mem_rdy     = rdy;
    bus.mem_data    = d;
    @(posedge clk);
    model_step();
    $display("cyc st=%0b rd=%0b rpc=%h rdy=%0b data=%h -> pc=%h pend=%0b halt=%0b",
             st, rd, rpc, rdy, d, m_pc, m_pending, m_halted);
  endtask

  // Asserts reset mid-cycle so the clearing is seen without any clock edge.
  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("rst_instruc", bus.instruc, 16'h0000);
    chk("rst_seq_pc", bus.seq_PC, 16'h0000);
    chk("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
    chk("rst_halted", {15'd0, bus.halted}, 16'd0);
    chk("rst_mem_addr", bus.mem_addr, RESET_PC);
    chk("rst_mem_rd", {15'd0, bus.mem_rd}, 16'd0);
    bus.mem_rdy  = 1'b1;
    bus.mem_data = 16'h5A5A;
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd_clk", {15'd0, bus.mem_rd}, 16'd0);
    chk("rst_valid_clk", {15'd0, bus.instr_valid}, 16'd0);
    @(negedge clk);
    bus.mem_rdy = 1'b0;
    exp_q.delete();
    m_pc      = RESET_PC;
    m_pending = 1'b0;
    m_halted  = 1'b0;
    rst       = 1'b1;
    chk_en    = 1'b1;
    $display("reset released");
  endtask

  // Monitor: compare every cycle, pop the head when the held word leaves.
  always @(negedge clk) begin
    #1;
    if (chk_en && rst) begin
      chk("mem_addr", bus.mem_addr, m_pc);
      chk("mem_rd", {15'd0, bus.mem_rd},
          {15'd0, (!m_halted && !m_pending && !bus.redirect)});
      chk("halted", {15'd0, bus.halted}, {15'd0, m_halted});
      chk("instr_valid", {15'd0, bus.instr_valid}, {15'd0, m_pending});
      if (bus.instr_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_nonempty", 16'd0, 16'd1);
        end else begin
          chk("instruc", bus.instruc, exp_q[0].ins);
          chk("seq_PC", bus.seq_PC, exp_q[0].spc);
          if (bus.redirect || !bus.stall) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [15:0] d;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_PC = 16'h0000;
    bus.mem_rdy     = 1'b0;
    bus.mem_data    = 16'h0000;
    m_pc      = RESET_PC;
    m_last    = 16'h0000;
    m_pending = 1'b0;
    m_halted  = 1'b0;
    do_reset();

    // Back-to-back fetches of a non-halt word.
    repeat (6) cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h4000);
    // Memory wait states while a request is pending.
    repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'hBEEF);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h4321);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    // Stalled decode holding 16'hC123.
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'hC123);
    repeat (5) cycle(1'b1, 1'b0, 16'h0, 1'b1, 16'h1111);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    // Redirect colliding with returning data; odd target aligned down.
    cycle(1'b0, 1'b1, 16'h0101, 1'b1, 16'h7777);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    // Wrap at the top of the address space.
    cycle(1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h2222);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    // HALT fetched, then attempts to wake it must be ignored.
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (4) cycle(1'b0, 1'b1, 16'h0040, 1'b1, 16'h4000);
    repeat (2) cycle(1'b1, 1'b0, 16'h0, 1'b1, 16'h4000);
    chk("halt_sticky", {15'd0, bus.halted}, 16'd1);
    do_reset();

    for (int seg = 0; seg < 5; seg++) begin
      for (int c = 0; c < 200; c++) begin
        logic st, rd, rdy;
        logic [15:0] rpc;
        st  = ($urandom_range(0, 99) < 30);
        rd  = ($urandom_range(0, 99) < 8);
        rdy = ($urandom_range(0, 99) < 60);
        case ($urandom_range(0, 3))
          0:       rpc = 16'hFFFE;
          1:       rpc = 16'hFFFF;
          default: rpc = 16'($urandom);
        endcase
        d = 16'($urandom);
        // Keep halts rare so segments run long enough to be interesting.
        if (d[15:11] == HALT_OPCODE && $urandom_range(0, 3) != 0) d[15] = 1'b1;
        cycle(st, rd, rpc, rdy, d);
      end
      do_reset();
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
